shim_ads816x_spi_responder: RTL and testbench
=============================================

SHIM_ADS816X_SPI_RESPONDER -- requirements
Module: shim_ads816x_spi_responder

Interface
REQ-001 SHALL have parameter ADS_MODEL_ID, default 8; 8/7/6 select ADS8168/8167/8166 timing; any other value selects ADS8166 timing.
REQ-002 SHALL have localparam N_CS_MIN_HIGH = 34 (model 8), 84 (model 7), 184 (model 6 and all other values), in clk cycles.
REQ-003 clk  input  1  single clock; SPI bit clock equals clk (one bit per cycle while n_cs low).
REQ-004 resetn  input  1  synchronous, active-low reset.
REQ-005 n_cs  input  1  chip select from controller, active low.
REQ-006 mosi  input  1  controller data, sampled on every rising clk edge with n_cs low, MSB first.
REQ-007 miso  output  1  responder data, MSB first.
REQ-008 sample_data  input  128  eight 16-bit channel values; channel k is sample_data[16k+15:16k].
REQ-009 otf_mode  output  1  current OTF_CFG bit 0.
REQ-010 last_ch  output  3  channel of the most recent accepted sample request.
REQ-011 frame_count  output  16  number of completed frames, wraps 0xFFFF->0.
REQ-012 frame_len_err, bad_spi_cmd, cs_high_violation  output  1 each  sticky error flags.

Function
REQ-013 SHALL count mosi bits per frame in a 5-bit rx_cnt saturating at 31; rx_shift is a 24-bit left shift register loaded with mosi at LSB.
REQ-014 Frame end SHALL be the first clk with n_cs high after a clk with n_cs low (registered n_cs_d); decode SHALL occur on that cycle using rx_cnt/rx_shift.
REQ-015 24-bit frame, rx_shift[23:19]=00001 (REG_WRITE): if addr rx_shift[18:8]=0x02A, OTF_CFG <= rx_shift[7:0]; other addresses ignored without error.
REQ-016 24-bit frame, 00010 (REG_READ): tx_next <= {OTF_CFG if addr=0x02A else 8'h00, 16'h0000}.
REQ-017 16-bit frame, otf_mode=1, rx_shift[15:14]=10: last_ch <= rx_shift[13:11]; tx_next <= {sample_data[last_ch new value], 8'h00}, value captured on the decode cycle.
REQ-018 Any other opcode in a 16- or 24-bit frame, or a 16-bit OTF request with otf_mode=0, SHALL set bad_spi_cmd and load tx_next with 0.
REQ-019 rx_cnt not 16 or 24 at frame end SHALL set frame_len_err, no decode, tx_next <= 0.
REQ-020 frame_count SHALL increment at every frame end, including errored frames.
REQ-021 On the first clk with n_cs low after n_cs high, tx_shift <= tx_next with tx_next consumed (cleared to 0); miso = tx_shift[23] while n_cs low, 0 while n_cs high.
REQ-022 tx_shift SHALL shift left by one (zero fill) on each subsequent clk with n_cs low; miso for frame bit i reflects response bit 23-i.
REQ-023 SHALL count consecutive n_cs-high cycles (8-bit, saturating 255); n_cs falling with count < N_CS_MIN_HIGH after at least one completed frame SHALL set cs_high_violation; frame still processed.
REQ-024 State machine: S_IDLE (n_cs high) -> S_FRAME on n_cs low; S_FRAME -> S_DECODE on n_cs high; S_DECODE -> S_IDLE next cycle, or S_FRAME if n_cs low again (decode still applied).
REQ-025 Sticky flags SHALL clear only on reset; they SHALL NOT block further frame processing.

Reset
REQ-026 resetn low: OTF_CFG=0, otf_mode=0, last_ch=0, frame_count=0, all flags 0, rx_cnt=0, tx_next=0, tx_shift=0, miso=0, high-cycle counter=255, state S_IDLE.
REQ-027 Reset mid-frame SHALL abandon the frame with no decode and no frame_count increment; the first frame after reset SHALL NOT set cs_high_violation.

Verification
REQ-028 24-bit frame 0x082A01 -> otf_mode=1, frame_count=1, no flags.
REQ-029 Frame 0x102A00 then 24-bit frame of zeros -> miso bits 0..7 of second frame = 0x01, remaining bits 0.
REQ-030 otf_mode=1, sample_data ch3=0xBEEF, 16-bit frame 0x9800 then 16-bit frame 0x8000 -> last_ch=3 then 0, second frame miso = 0xBEEF.
REQ-031 ADS_MODEL_ID=8, n_cs high 20 cycles between frames -> cs_high_violation=1; high 34 cycles -> stays 0.
REQ-032 12-bit frame -> frame_len_err=1, next frame miso all 0; 16-bit OTF request with otf_mode=0 -> bad_spi_cmd=1.
REQ-033 resetn low at bit 10 of a 24-bit write -> OTF_CFG=0, frame_count=0, no flags after reset.

Source files
------------

// File: rtl/shim_ads816x_spi_responder.sv
// Cycle-level stand-in for an ADS8166/7/8 SPI responder: it decodes register
// write/read and on-the-fly channel requests and shifts the response out on miso.
module shim_ads816x_spi_responder #(
  parameter int ADS_MODEL_ID = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         n_cs,
  input  logic         mosi,
  output logic         miso,
  input  logic [127:0] sample_data,
  output logic         otf_mode,
  output logic [2:0]   last_ch,
  output logic [15:0]  frame_count,
  output logic         frame_len_err,
  output logic         bad_spi_cmd,
  output logic         cs_high_violation
);

  localparam int N_CS_MIN_HIGH = (ADS_MODEL_ID == 8) ? 34 :
                                 (ADS_MODEL_ID == 7) ? 84 : 184;
  localparam logic [7:0]  CS_MIN     = 8'(N_CS_MIN_HIGH);
  localparam logic [10:0] OTF_ADDR   = 11'h02A;
  localparam logic [4:0]  OP_WRITE   = 5'b00001;
  localparam logic [4:0]  OP_READ    = 5'b00010;

  typedef enum logic [1:0] {S_IDLE, S_FRAME, S_DECODE} state_t;

  state_t      state;
  logic [4:0]  rx_cnt;
  logic [23:0] rx_shift;
  logic [23:0] tx_next;
  logic [23:0] tx_shift;
  logic [7:0]  otf_cfg;
  logic [7:0]  hi_cnt;
  logic        frame_seen;

  // S_FRAME is exactly "n_cs was low on the previous clk".
  logic frame_start, frame_end;
  assign frame_start = !n_cs && (state != S_FRAME);
  assign frame_end   = n_cs && (state == S_FRAME);

  assign otf_mode = otf_cfg[0];
  assign miso     = n_cs ? 1'b0 : tx_shift[23];

  logic [23:0] dec_tx;
  logic        dec_bad, dec_len_err, cfg_wr, ch_wr;
  logic [2:0]  req_ch;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and a latch cannot be inferred.
  always_comb begin
    dec_tx      = '0;
    dec_bad     = 1'b0;
    dec_len_err = 1'b0;
    cfg_wr      = 1'b0;
    ch_wr       = 1'b0;
    req_ch      = rx_shift[13:11];
    if (rx_cnt == 5'd24) begin
      case (rx_shift[23:19])
        OP_WRITE: cfg_wr = (rx_shift[18:8] == OTF_ADDR);
        OP_READ:  dec_tx = {(rx_shift[18:8] == OTF_ADDR) ? otf_cfg : 8'h00, 16'h0000};
        default:  dec_bad = 1'b1;
      endcase
    end else if (rx_cnt == 5'd16) begin
      if (otf_cfg[0] && rx_shift[15:14] == 2'b10) begin
        ch_wr  = 1'b1;
        dec_tx = {sample_data[{req_ch, 4'b0000} +: 16], 8'h00};
      end else begin
        dec_bad = 1'b1;
      end
    end else begin
      dec_len_err = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state             <= S_IDLE;
      rx_cnt            <= '0;
      rx_shift          <= '0;
      tx_next           <= '0;
      tx_shift          <= '0;
      otf_cfg           <= '0;
      last_ch           <= '0;
      frame_count       <= '0;
      frame_len_err     <= 1'b0;
      bad_spi_cmd       <= 1'b0;
      cs_high_violation <= 1'b0;
      hi_cnt            <= 8'hFF;
      frame_seen        <= 1'b0;
    end else begin
      case (state)
        S_IDLE:   if (!n_cs) state <= S_FRAME;
        S_FRAME:  if (n_cs) state <= S_DECODE;
        default:  state <= n_cs ? S_IDLE : S_FRAME;
      endcase

      if (!n_cs) hi_cnt <= '0;
      else if (hi_cnt != 8'hFF) hi_cnt <= hi_cnt + 8'd1;

      if (frame_start) begin
        rx_cnt   <= 5'd1;
        rx_shift <= {23'b0, mosi};
        tx_shift <= tx_next;
        tx_next  <= '0;
        if (frame_seen && hi_cnt < CS_MIN) cs_high_violation <= 1'b1;
      end else if (!n_cs) begin
        if (rx_cnt != 5'd31) rx_cnt <= rx_cnt + 5'd1;
        rx_shift <= {rx_shift[22:0], mosi};
        tx_shift <= {tx_shift[22:0], 1'b0};
      end

      // Errored frames still count and still replace the pending response.
      if (frame_end) begin
        frame_count <= frame_count + 16'd1;
        frame_seen  <= 1'b1;
        tx_next     <= dec_tx;
        if (dec_len_err) frame_len_err <= 1'b1;
        if (dec_bad)     bad_spi_cmd   <= 1'b1;
        if (cfg_wr)      otf_cfg       <= rx_shift[7:0];
        if (ch_wr)       last_ch       <= req_ch;
      end
    end
  end

endmodule

// File: tb/tb_shim_ads816x_spi_responder.sv
// Directed bench for shim_ads816x_spi_responder: a table of frames with
// expected responses and status, plus chip-select timing and reset sequences.
module tb_shim_ads816x_spi_responder;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         n_cs = 1'b1;
  logic         mosi = 1'b0;
  logic         miso;
  logic [127:0] sample_data;
  logic         otf_mode;
  logic [2:0]   last_ch;
  logic [15:0]  frame_count;
  logic         frame_len_err, bad_spi_cmd, cs_high_violation;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shim_ads816x_spi_responder #(.ADS_MODEL_ID(8)) dut (
    .clk(clk), .resetn(resetn), .n_cs(n_cs), .mosi(mosi), .miso(miso),
    .sample_data(sample_data), .otf_mode(otf_mode), .last_ch(last_ch),
    .frame_count(frame_count), .frame_len_err(frame_len_err),
    .bad_spi_cmd(bad_spi_cmd), .cs_high_violation(cs_high_violation)
  );

  typedef struct {
    bit          rst;
    int          len;
    logic [23:0] frame;
    logic [23:0] exp_miso;
    logic        exp_otf;
    logic [2:0]  exp_ch;
    logic [15:0] exp_fc;
    logic [2:0]  exp_flags;   // {frame_len_err, bad_spi_cmd, cs_high_violation}
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    n_cs   = 1'b1;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  // Bit i is driven before edge i; miso is captured 1 ns after edge i.
  task automatic send_frame(input int len, input logic [23:0] data, input int gap,
                            output logic [23:0] rx);
    rx = '0;
    for (int i = 0; i < len; i++) begin
      n_cs = 1'b0;
      mosi = data[len-1-i];
      @(posedge clk);
      #1 rx = {rx[22:0], miso};
    end
    n_cs = 1'b1;
    mosi = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag, input logic [2:0] flags,
                              input logic [15:0] fc);
    check({tag, " flags"}, {29'b0, frame_len_err, bad_spi_cmd, cs_high_violation}, {29'b0, flags});
    check({tag, " frame_count"}, {16'b0, frame_count}, {16'b0, fc});
  endtask

  initial begin
    logic [23:0] rx;

    sample_data = {16'h7777, 16'h6666, 16'hA5C3, 16'h4444,
                   16'hBEEF, 16'h2222, 16'h1111, 16'h1234};

    //          rst len frame       exp_miso    otf ch fc  flags
    vecs[0]  = '{1, 16, 24'h009800, 24'h000000, 0, 0, 1,  3'b010};
    vecs[1]  = '{1, 24, 24'h082A01, 24'h000000, 1, 0, 1,  3'b000};
    vecs[2]  = '{0, 16, 24'h009800, 24'h000000, 1, 3, 2,  3'b000};
    vecs[3]  = '{0, 16, 24'h008000, 24'h00BEEF, 1, 0, 3,  3'b000};
    vecs[4]  = '{0, 16, 24'h00A800, 24'h001234, 1, 5, 4,  3'b000};
    vecs[5]  = '{0, 24, 24'h102A00, 24'hA5C300, 1, 5, 5,  3'b000};
    vecs[6]  = '{0, 24, 24'h082B77, 24'h010000, 1, 5, 6,  3'b000};
    vecs[7]  = '{0, 24, 24'h102B00, 24'h000000, 1, 5, 7,  3'b000};
    vecs[8]  = '{0, 24, 24'h102A00, 24'h000000, 1, 5, 8,  3'b000};
    vecs[9]  = '{0, 24, 24'h000000, 24'h010000, 1, 5, 9,  3'b010};
    vecs[10] = '{0, 12, 24'h000ABC, 24'h000000, 1, 5, 10, 3'b110};
    vecs[11] = '{0, 24, 24'h102A00, 24'h000000, 1, 5, 11, 3'b110};
    vecs[12] = '{1, 24, 24'h082A01, 24'h000000, 1, 0, 1,  3'b000};
    vecs[13] = '{0, 16, 24'h004000, 24'h000000, 1, 0, 2,  3'b010};
    vecs[14] = '{0, 16, 24'h009800, 24'h000000, 1, 3, 3,  3'b010};
    vecs[15] = '{0, 16, 24'h00F800, 24'h00BEEF, 1, 3, 4,  3'b010};

    do_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset miso", {31'b0, miso}, 32'd0);
    check("reset otf_mode", {31'b0, otf_mode}, 32'd0);
    check("reset last_ch", {29'b0, last_ch}, 32'd0);
    check_status("reset", 3'b000, 16'd0);

    for (int v = 0; v < 16; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      if (vecs[v].rst) do_reset();
      send_frame(vecs[v].len, vecs[v].frame, 40, rx);
      check({tag, " miso"}, {8'b0, rx}, {8'b0, vecs[v].exp_miso});
      check({tag, " otf_mode"}, {31'b0, otf_mode}, {31'b0, vecs[v].exp_otf});
      check({tag, " last_ch"}, {29'b0, last_ch}, {29'b0, vecs[v].exp_ch});
      check_status(tag, vecs[v].exp_flags, vecs[v].exp_fc);
    end

    // Chip-select high time: 34 cycles is legal, 33 is one short.
    do_reset();
    send_frame(24, 24'h082A01, 34, rx);
    send_frame(16, 24'h009800, 33, rx);
    check_status("cs gap34", 3'b000, 16'd2);
    send_frame(16, 24'h008000, 40, rx);
    check_status("cs gap33", 3'b001, 16'd3);
    check("cs gap33 miso", {8'b0, rx}, 32'h0000BEEF);
    check("cs gap33 last_ch", {29'b0, last_ch}, 32'd0);

    do_reset();
    send_frame(24, 24'h082A01, 20, rx);
    send_frame(24, 24'h082A00, 40, rx);
    check_status("cs gap20", 3'b001, 16'd2);
    check("cs gap20 otf_mode", {31'b0, otf_mode}, 32'd0);

    // Reset asserted at bit 10 of a write abandons it; a quick first frame
    // after reset must not flag a chip-select violation.
    do_reset();
    send_frame(24, 24'h082A01, 40, rx);
    for (int i = 0; i < 24; i++) begin
      if (i == 10) resetn = 1'b0;
      n_cs = 1'b0;
      mosi = 1'b1;
      @(posedge clk);
      #1;
    end
    n_cs = 1'b1;
    mosi = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("midreset otf_mode", {31'b0, otf_mode}, 32'd0);
    check_status("midreset", 3'b000, 16'd0);
    send_frame(24, 24'h082A01, 40, rx);
    check("postreset otf_mode", {31'b0, otf_mode}, 32'd1);
    check_status("postreset", 3'b000, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
